// File: rtl/pmux_sel_ctrl.sv
// pmux_sel_ctrl
//   Selection controller for a 4-input pin mux.
//   - Holds the committed selection and drives the one-hot mux selects.
//   - Switches break-before-make: every select is low for BREAK_CYCLES
//     cycles before the new select rises.
//   - Supports a sticky lock that rejects all later writes.
//
// Parameters
//   BREAK_CYCLES  all-deasserted cycles between selections (1..15)
//   RESET_SEL     selection index applied at reset (0=a .. 3=d)
//
// Ports
//   clk                  sole clock, rising edge
//   rst                  synchronous active-high reset
//   wr_valid/wr_ready    selection write handshake
//   wr_sel               requested selection index
//   wr_lock              lock the configuration once this write is applied
//   sels_sel_a..d        registered one-hot mux selects
//   cur_sel              committed selection index
//   busy                 switch in progress
//   locked               configuration locked (sticky until rst)
//   err_locked           one-cycle pulse for a write rejected while locked
module pmux_sel_ctrl #(
  parameter int unsigned BREAK_CYCLES = 2,
  parameter logic [1:0]  RESET_SEL    = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_sel,
  input  logic       wr_lock,
  output logic       sels_sel_a,
  output logic       sels_sel_b,
  output logic       sels_sel_c,
  output logic       sels_sel_d,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       locked,
  output logic       err_locked
);

  typedef enum logic {
    IDLE  = 1'b0,
    BREAK = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(BREAK_CYCLES - 1);

  function automatic logic [3:0] sel_onehot(input logic [1:0] s);
    sel_onehot = 4'b0001 << s;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cur_sel_q, cur_sel_d;
  logic [3:0] sels_q, sels_d;
  logic       busy_q, busy_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       accept;

  // Ready is derived only from registered state and rst, never from the
  // write inputs, so there is no combinational loop through the handshake.
  assign wr_ready = (state_q == IDLE) && !locked_q && !rst;
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    sels_d    = sels_q;
    busy_d    = busy_q;
    locked_d  = locked_q;
    // A locked write is only an error when it is actually being refused in
    // IDLE; requests during BREAK are simply held off by wr_ready.
    err_d     = wr_valid && locked_q && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr_lock) locked_d = 1'b1;
          // Rewriting the current selection is a no-op: no break, no glitch.
          if (wr_sel != cur_sel_q) begin
            state_d   = BREAK;
            cur_sel_d = wr_sel;
            sels_d    = 4'b0000;
            busy_d    = 1'b1;
            cnt_d     = CNT_LOAD;
          end
        end
      end
      BREAK: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          sels_d  = sel_onehot(cur_sel_q);
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      cur_sel_q <= RESET_SEL;
      sels_q    <= sel_onehot(RESET_SEL);
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      sels_q    <= sels_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign sels_sel_a = sels_q[0];
  assign sels_sel_b = sels_q[1];
  assign sels_sel_c = sels_q[2];
  assign sels_sel_d = sels_q[3];
  assign cur_sel    = cur_sel_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign err_locked = err_q;

endmodule

// File: tb/tb_pmux_sel_ctrl.sv
// Testbench for pmux_sel_ctrl with default parameters (BREAK_CYCLES=2,
// RESET_SEL=0). Inputs are driven and outputs sampled on the falling edge.
module tb_pmux_sel_ctrl;

  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_sel;
  logic       wr_lock;
  logic       sels_sel_a, sels_sel_b, sels_sel_c, sels_sel_d;
  logic [1:0] cur_sel;
  logic       busy;
  logic       locked;
  logic       err_locked;

  int tests_run    = 0;
  int tests_failed = 0;

  pmux_sel_ctrl #(.BREAK_CYCLES(BC), .RESET_SEL(2'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_lock    (wr_lock),
    .sels_sel_a (sels_sel_a),
    .sels_sel_b (sels_sel_b),
    .sels_sel_c (sels_sel_c),
    .sels_sel_d (sels_sel_d),
    .cur_sel    (cur_sel),
    .busy       (busy),
    .locked     (locked),
    .err_locked (err_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sels();
    return {sels_sel_d, sels_sel_c, sels_sel_b, sels_sel_a};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 2'd0; wr_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b1; wr_sel = 2'd3; wr_lock = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (sels() !== 4'b0001 || cur_sel !== 2'd0 || busy !== 1'b0 ||
        locked !== 1'b0 || err_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: sels=%b cur=%0d busy=%b locked=%b err=%b, want 0001 0 0 0 0",
               sels(), cur_sel, busy, locked, err_locked);
    end
    tests_run++;
    if (wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_in_rst: wr_ready=%b want 0", wr_ready);
    end
    rst = 1'b0; wr_valid = 1'b0; wr_sel = 2'd0; wr_lock = 1'b0;
    @(negedge clk);
    tests_run++;
    if (wr_ready !== 1'b1 || sels() !== 4'b0001 || cur_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b sels=%b cur=%0d, want 1 0001 0",
               wr_ready, sels(), cur_sel);
    end
  endtask

  task automatic test_switch();
    @(negedge clk);
    wr_valid = 1'b1; wr_sel = 2'd2;
    #1;
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL switch_ready_before: wr_ready=%b want 1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    for (int i = 0; i < BC; i++) begin
      tests_run++;
      if (sels() !== 4'b0000 || busy !== 1'b1 || wr_ready !== 1'b0 || cur_sel !== 2'd2) begin
        tests_failed++;
        $display("FAIL switch_break%0d: sels=%b busy=%b ready=%b cur=%0d, want 0000 1 0 2",
                 i, sels(), busy, wr_ready, cur_sel);
      end
      @(negedge clk);
    end
    tests_run++;
    if (sels() !== 4'b0100 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL switch_done: sels=%b busy=%b ready=%b, want 0100 0 1",
               sels(), busy, wr_ready);
    end
  endtask

  task automatic test_same_sel();
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_sel = 2'd0;
    @(negedge clk);
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sels() !== 4'b0001 || busy !== 1'b0 || wr_ready !== 1'b1 || cur_sel !== 2'd0) begin
        tests_failed++;
        $display("FAIL same_sel%0d: sels=%b busy=%b ready=%b cur=%0d, want 0001 0 1 0",
                 i, sels(), busy, wr_ready, cur_sel);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_sel = 2'd3; wr_lock = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_lock = 1'b0;
    tests_run++;
    if (locked !== 1'b1 || busy !== 1'b1 || sels() !== 4'b0000 || err_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_accept: locked=%b busy=%b sels=%b err=%b, want 1 1 0000 0",
               locked, busy, sels(), err_locked);
    end
    repeat (BC) @(negedge clk);
    tests_run++;
    if (sels() !== 4'b1000 || locked !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_done: sels=%b locked=%b ready=%b busy=%b, want 1000 1 0 0",
               sels(), locked, wr_ready, busy);
    end
    wr_valid = 1'b1; wr_sel = 2'd1;
    @(negedge clk);
    wr_valid = 1'b0;
    tests_run++;
    if (err_locked !== 1'b1 || sels() !== 4'b1000 || cur_sel !== 2'd3) begin
      tests_failed++;
      $display("FAIL lock_err_pulse: err=%b sels=%b cur=%0d, want 1 1000 3",
               err_locked, sels(), cur_sel);
    end
    @(negedge clk);
    tests_run++;
    if (err_locked !== 1'b0 || sels() !== 4'b1000 || locked !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_err_end: err=%b sels=%b locked=%b busy=%b, want 0 1000 1 0",
               err_locked, sels(), locked, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_sel = 2'd1;
    @(negedge clk);
    wr_sel = 2'd3;                     // held request during the break
    for (int i = 0; i < BC; i++) begin
      tests_run++;
      if (wr_ready !== 1'b0 || err_locked !== 1'b0 || sels() !== 4'b0000) begin
        tests_failed++;
        $display("FAIL b2b_hold%0d: ready=%b err=%b sels=%b, want 0 0 0000",
                 i, wr_ready, err_locked, sels());
      end
      @(negedge clk);
    end
    tests_run++;
    if (sels() !== 4'b0010 || wr_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: sels=%b ready=%b busy=%b, want 0010 1 0",
               sels(), wr_ready, busy);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    tests_run++;
    if (sels() !== 4'b0000 || busy !== 1'b1 || cur_sel !== 2'd3) begin
      tests_failed++;
      $display("FAIL b2b_second: sels=%b busy=%b cur=%0d, want 0000 1 3",
               sels(), busy, cur_sel);
    end
    repeat (BC) @(negedge clk);
    tests_run++;
    if (sels() !== 4'b1000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_done: sels=%b busy=%b, want 1000 0", sels(), busy);
    end
  endtask

  task automatic test_rst_mid_break();
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_sel = 2'd1; wr_lock = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_lock = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (sels() !== 4'b0001 || busy !== 1'b0 || locked !== 1'b0 || cur_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_break: sels=%b busy=%b locked=%b cur=%0d, want 0001 0 0 0",
               sels(), busy, locked, cur_sel);
    end
  endtask

  task automatic test_random();
    logic       pending;
    int         zcnt;
    logic [1:0] target;
    do_reset();
    pending = 1'b0;
    zcnt    = 0;
    target  = 2'd0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      tests_run++;
      if ($countones(sels()) > 1 || (!busy && sels() !== (4'b0001 << cur_sel))) begin
        tests_failed++;
        $display("FAIL rand_onehot cyc=%0d: sels=%b busy=%b cur=%0d", cyc, sels(), busy, cur_sel);
      end
      if (pending) begin
        tests_run++;
        if (zcnt < BC) begin
          if (sels() !== 4'b0000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rand_break cyc=%0d: sels=%b busy=%b, want 0000 1", cyc, sels(), busy);
          end
          zcnt++;
        end else begin
          if (sels() !== (4'b0001 << target) || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_break_end cyc=%0d: sels=%b busy=%b, want %b 0",
                     cyc, sels(), busy, 4'b0001 << target);
          end
          pending = 1'b0;
        end
      end
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_sel   = 2'($urandom_range(0, 3));
      wr_lock  = 1'b0;
      #1;
      tests_run++;
      if (wr_ready !== !pending) begin
        tests_failed++;
        $display("FAIL rand_ready cyc=%0d: wr_ready=%b want %b", cyc, wr_ready, !pending);
      end
      if (wr_valid && !pending && wr_sel != cur_sel) begin
        pending = 1'b1;
        zcnt    = 0;
        target  = wr_sel;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 2'd0; wr_lock = 1'b0;
    test_reset();
    test_switch();
    test_same_sel();
    test_lock();
    test_back_to_back();
    test_rst_mid_break();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pmux_sel_ctrl.md
PMUX_SEL_CTRL -- requirements
Module: pmux_sel_ctrl

Purpose: upstream stage for the 4-input pin mux. Holds the mux selection and drives its one-hot select lines sels_sel_a..sels_sel_d, with break-before-make switching and a sticky lock.

Interface
REQ-001 The block SHALL have parameter BREAK_CYCLES, default 2, giving the number of all-deasserted cycles between selections (legal 1..15).
REQ-002 The block SHALL have parameter RESET_SEL, default 0, giving the selection index applied at reset (0=a, 1=b, 2=c, 3=d).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wr_valid  in  1  selection write request.
REQ-006 wr_ready  out  1  block can accept a write this cycle.
REQ-007 wr_sel  in  2  requested selection index.
REQ-008 wr_lock  in  1  lock the configuration once this write is applied.
REQ-009 sels_sel_a, sels_sel_b, sels_sel_c, sels_sel_d  out  1 each  one-hot mux selects to the pin mux.
REQ-010 cur_sel  out  2  index of the committed selection.
REQ-011 busy  out  1  high while a switch is in progress.
REQ-012 locked  out  1  configuration locked.
REQ-013 err_locked  out  1  one-cycle pulse flagging a rejected write while locked.

Function
REQ-014 The block SHALL implement FSM states IDLE and BREAK.
REQ-015 wr_ready SHALL equal (state==IDLE) and not locked and not rst; it SHALL be combinational from registered state.
REQ-016 A write SHALL be accepted on a rising edge where wr_valid and wr_ready are both high.
REQ-017 On an accepted write with wr_sel==cur_sel, the FSM SHALL remain in IDLE and the selects SHALL be unchanged.
REQ-018 On an accepted write with wr_sel!=cur_sel, at that edge:
- the FSM SHALL enter BREAK;
- cur_sel SHALL take wr_sel;
- all four selects SHALL go low;
- busy SHALL go high;
- a down-counter SHALL load BREAK_CYCLES-1.
REQ-019 In BREAK, the counter SHALL decrement each cycle. On the edge where it reads 0, the FSM SHALL return to IDLE, assert only the select matching cur_sel, and clear busy.
REQ-020 Timing: accept at edge N, then selects all low for cycles N+1..N+BREAK_CYCLES, then the new select high from cycle N+BREAK_CYCLES+1.
REQ-021 At most one select SHALL be high in any cycle. All select outputs SHALL be registered (no combinational path from inputs).
REQ-022 If wr_lock is high on an accepted write, locked SHALL set at the accept edge. The pending switch, if any, SHALL still complete.
REQ-023 locked SHALL be sticky; only rst clears it.
REQ-024 wr_valid high while locked and in IDLE SHALL pulse err_locked high for exactly one cycle per requesting cycle. Such a write SHALL have no other effect.
REQ-025 wr_valid high during BREAK SHALL be held off by wr_ready low. It SHALL not be an error and SHALL be accepted once IDLE is reached, if still unlocked.
REQ-026 The 2-bit wr_sel SHALL be decoded fully; every index value is legal.

Reset
REQ-027 While rst is high at an edge, the block SHALL set:
- state IDLE, counter 0;
- cur_sel = RESET_SEL, with only the select matching RESET_SEL high;
- busy 0, locked 0, err_locked 0.
REQ-028 rst asserted mid-BREAK SHALL abort the switch and restore the RESET_SEL selection at that edge.
REQ-029 Writes presented while rst is high SHALL be ignored (wr_ready low).

Verification
REQ-030 Reset with defaults -> sels_sel_a=1, others 0, cur_sel=0, wr_ready=1 the cycle after rst falls.
REQ-031 Write wr_sel=2, BREAK_CYCLES=2 -> all selects 0 for 2 cycles, then sels_sel_c=1; busy high exactly 2 cycles; wr_ready low during them.
REQ-032 Write wr_sel=0 while cur_sel=0 -> accepted in one cycle, no select glitch, busy stays 0.
REQ-033 Write wr_sel=3 with wr_lock=1, then write wr_sel=1 -> sels_sel_d=1 after the break, locked=1, second write gives one err_locked pulse, selects unchanged.
REQ-034 Assert rst during the BREAK of a switch to index 1 -> next cycle sels_sel_a=1, busy=0, locked=0.
REQ-035 Random back-to-back writes for 10k cycles -> checker confirms the one-hot-or-zero invariant every cycle and the exact break length on every switch.
